// File: rtl/z80_cb_ind_hl_rmw_seq.sv
// Bus sequencer for BIT/RES/SET b,(HL): reads (HL), waits INT_CYCLES internal
// cycles while modifying the byte, writes it back for RES/SET, then reports
// the next IP (and Z for BIT) with a one-cycle done pulse.
module z80_cb_ind_hl_rmw_seq #(
    parameter int unsigned INT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  b,
    input  logic [15:0] hl,
    input  logic [15:0] ip,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [15:0] ip_out,
    output logic        z_valid,
    output logic        z_out,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MOD,
        S_WR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_BIT = 2'b00,
        OP_RES = 2'b01,
        OP_SET = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [2:0] MOD_LAST = 3'(INT_CYCLES - 1);

    state_t      state_q, state_d;
    op_t         op_q;
    logic [2:0]  b_q;
    logic [15:0] hl_q;
    logic [15:0] ip_q;
    logic [7:0]  data_q;
    logic        z_q;
    logic [2:0]  cnt_q;
    logic        err_q;

    logic        accept;
    logic        mod_last;
    logic [7:0]  bit_mask;
    logic [7:0]  mod_byte;

    assign accept   = (state_q == S_IDLE) && start && (op != OP_ILL);
    assign mod_last = (cnt_q == MOD_LAST);
    assign bit_mask = 8'b1 << b_q;

    // Modified byte for the write-back; BIT leaves the data untouched
    always_comb begin
        mod_byte = data_q;
        case (op_q)
            OP_SET:  mod_byte = data_q | bit_mask;
            OP_RES:  mod_byte = data_q & ~bit_mask;
            default: mod_byte = data_q;
        endcase
    end

    // State register; reset drops any pending transfer immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; everything idles at zero outside its state
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        ip_out    = '0;
        z_valid   = 1'b0;
        z_out     = 1'b0;
        err       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RD;
            end
            S_RD: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = hl_q;
                if (mem_ack) state_d = S_MOD;
            end
            S_MOD: begin
                busy = 1'b1;
                if (mod_last) state_d = (op_q == OP_BIT) ? S_DONE : S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hl_q;
                mem_wdata = data_q;
                if (mem_ack) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                ip_out  = ip_q + 16'd2;
                z_valid = (op_q == OP_BIT);
                z_out   = (op_q == OP_BIT) && z_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, read capture, modify counter and error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= OP_BIT;
            b_q    <= '0;
            hl_q   <= '0;
            ip_q   <= '0;
            data_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start && (op == OP_ILL);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        op_q <= op_t'(op);
                        b_q  <= b;
                        hl_q <= hl;
                        ip_q <= ip;
                    end
                end
                S_RD: begin
                    cnt_q <= '0;
                    if (mem_ack) data_q <= mem_rdata;
                end
                S_MOD: begin
                    cnt_q <= cnt_q + 3'd1;
                    // data_q is the write source, so fold the result in once at the end
                    if (mod_last) begin
                        data_q <= mod_byte;
                        z_q    <= ~data_q[b_q];
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_cb_ind_hl_rmw_seq.sv
// Scoreboard bench for z80_cb_ind_hl_rmw_seq: the driver pushes expected bus
// transfers and completions; a monitor pops and compares as the DUT presents them.
module tb_z80_cb_ind_hl_rmw_seq;

    localparam int INT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  b;
    logic [15:0] hl;
    logic [15:0] ip;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        done;
    logic [15:0] ip_out;
    logic        z_valid;
    logic        z_out;
    logic        err;

    z80_cb_ind_hl_rmw_seq #(.INT_CYCLES(INT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .b         (b),
        .hl        (hl),
        .ip        (ip),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .ip_out    (ip_out),
        .z_valid   (z_valid),
        .z_out     (z_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // kind: 0 = read, 1 = write, 2 = done, 3 = err
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        zv;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [7:0] mem_val  = 8'h00;
    int         wait_rd  = 0;
    int         wait_wr  = 0;
    bit         hold_wr  = 1'b0;
    int         wcnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: inserts the configured wait cycles, then acks
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_rdata = mem_val;
            if (!reset_n) begin
                wcnt    = 0;
                mem_ack = 1'b0;
            end else if (mem_req && !(hold_wr && mem_we)) begin
                if (wcnt == (mem_we ? wait_wr : wait_rd)) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: compares every transfer, done and err against the queue head
    initial begin
        exp_t e;
        bit   prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                prev_done = 1'b0;
                continue;
            end
            if (prev_done) chk("busy_fall", busy, 0);
            prev_done = done;
            if (mem_req && mem_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_xfer", {15'd0, mem_we, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("xfer_kind", {31'd0, mem_we}, e.kind);
                    chk("xfer_addr", mem_addr, e.addr);
                    if (e.kind == 1) chk("xfer_wdata", mem_wdata, e.data);
                    chk("xfer_cycle", cyc, e.cyc);
                end
            end else if (mem_req && q.size() != 0) begin
                chk("wait_addr_stable", mem_addr, q[0].addr);
                if (mem_we && q[0].kind == 1) chk("wait_wdata_stable", mem_wdata, q[0].data);
            end
            if (done || err) begin
                if (q.size() == 0) begin
                    chk("unexpected_done_err", {30'd0, done, err}, 0);
                end else begin
                    e = q.pop_front();
                    chk("resp_kind", done ? 2 : 3, e.kind);
                    chk("resp_cycle", cyc, e.cyc);
                    if (e.kind == 2) begin
                        chk("done_ip_out", ip_out, e.addr);
                        chk("done_z_valid", z_valid, e.zv);
                        if (e.zv) chk("done_z_out", z_out, e.z);
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_z_valid"}, z_valid, 0);
        chk({tag, "_z_out"}, z_out, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ip_out"}, ip_out, 0);
    endtask

    task automatic wait_drain(input bit poke);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            if (poke && busy) begin
                start = 1'b1;
                op    = 2'b10;
                b     = 3'd5;
                hl    = 16'hAAAA;
                ip    = 16'h5555;
            end else begin
                start = 1'b0;
            end
            #2;
            n++;
        end
        start = 1'b0;
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [2:0] bi, input logic [15:0] h,
                          input logic [15:0] ipv, input logic [7:0] mv, input int wr, input int ww,
                          input logic [7:0] exp_wd, input logic [15:0] exp_ip, input logic exp_z,
                          input bit poke);
        int   s;
        exp_t e;
        @(negedge clk);
        mem_val = mv;
        wait_rd = wr;
        wait_wr = ww;
        start   = 1'b1;
        op      = o;
        b       = bi;
        hl      = h;
        ip      = ipv;
        s       = cyc;
        e = '{kind: 0, addr: h, data: 8'h00, zv: 1'b0, z: 1'b0, cyc: s + 1 + wr};
        q.push_back(e);
        if (o != 2'b00) begin
            e = '{kind: 1, addr: h, data: exp_wd, zv: 1'b0, z: 1'b0, cyc: s + 2 + wr + INT + ww};
            q.push_back(e);
            e = '{kind: 2, addr: exp_ip, data: 8'h00, zv: 1'b0, z: 1'b0, cyc: s + 3 + wr + INT + ww};
        end else begin
            e = '{kind: 2, addr: exp_ip, data: 8'h00, zv: 1'b1, z: exp_z, cyc: s + 2 + wr + INT};
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        wait_drain(poke);
    endtask

    task automatic err_op();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        b     = 3'd2;
        hl    = 16'h3333;
        ip    = 16'h4444;
        e = '{kind: 3, addr: 16'h0000, data: 8'h00, zv: 1'b0, z: 1'b0, cyc: cyc + 1};
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_busy_low", busy, 0);
        wait_drain(1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_in_write();
        exp_t e;
        int   n;
        @(negedge clk);
        hold_wr = 1'b1;
        mem_val = 8'h55;
        wait_rd = 0;
        start   = 1'b1;
        op      = 2'b10;
        b       = 3'd1;
        hl      = 16'h2000;
        ip      = 16'h0300;
        e = '{kind: 0, addr: 16'h2000, data: 8'h00, zv: 1'b0, z: 1'b0, cyc: cyc + 1};
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("rst_reached_wr", {31'd0, mem_req && mem_we}, 1);
        repeat (2) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        chk("rst_read_seen", q.size(), 0);
        q.delete();
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_held");
        @(negedge clk);
        hold_wr = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        b       = 3'd0;
        hl      = 16'h0000;
        ip      = 16'h0000;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        //     op     b     hl        ip        mem    wr ww  wdata  ip_out    z     poke
        run_op(2'b10, 3'd3, 16'h1234, 16'h0100, 8'h00, 0, 0, 8'h08, 16'h0102, 1'b0, 1'b0);
        run_op(2'b01, 3'd7, 16'h4000, 16'h0200, 8'hFF, 2, 1, 8'h7F, 16'h0202, 1'b0, 1'b0);
        run_op(2'b00, 3'd0, 16'h5000, 16'h0300, 8'hFE, 0, 0, 8'h00, 16'h0302, 1'b1, 1'b0);
        run_op(2'b00, 3'd0, 16'h5000, 16'h0300, 8'h01, 0, 0, 8'h00, 16'h0302, 1'b0, 1'b0);
        run_op(2'b10, 3'd0, 16'hFFFF, 16'hFFFF, 8'h00, 0, 0, 8'h01, 16'h0001, 1'b0, 1'b0);
        run_op(2'b01, 3'd2, 16'h0042, 16'h1000, 8'hA5, 1, 2, 8'hA1, 16'h1002, 1'b0, 1'b1);
        run_op(2'b00, 3'd6, 16'h0777, 16'h2000, 8'h40, 1, 0, 8'h00, 16'h2002, 1'b0, 1'b1);
        run_op(2'b00, 3'd5, 16'h0777, 16'h2000, 8'h40, 0, 0, 8'h00, 16'h2002, 1'b1, 1'b0);
        err_op();
        reset_in_write();
        run_op(2'b10, 3'd7, 16'h0BEE, 16'h7FFE, 8'h01, 0, 0, 8'h81, 16'h8000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
